// File: rtl/memory_access_controller_if.sv
// Request/response channel bundle for memory_access_controller.
// slave modport is the controller side; master modport is the requester side.
interface memory_access_controller_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_write;
    logic [ADDR_W-1:0] i_req_address;
    logic [DATA_W-1:0] i_req_wdata;
    logic              o_resp_valid;
    logic              i_resp_ready;
    logic [DATA_W-1:0] o_resp_rdata;
    logic              o_resp_error;

    modport slave (
        input  i_req_valid, i_req_write, i_req_address, i_req_wdata, i_resp_ready,
        output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_error
    );

    modport master (
        output i_req_valid, i_req_write, i_req_address, i_req_wdata, i_resp_ready,
        input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_error
    );
endinterface

// File: rtl/memory_access_controller.sv
// Single-word read/write sequencer for the 8x8 array and its address decoder.
// Define WRITE_VERIFY_EN to add a read-back VERIFY state after every write.
module memory_access_controller #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 3,
    parameter int SETUP_CYCLES = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    memory_access_controller_if.slave bus,
    output logic [ADDR_W-1:0]         o_k_address,
    output logic                      o_valid,
    output logic                      o_array_we,
    output logic [DATA_W-1:0]         o_array_wdata,
    input  logic [DATA_W-1:0]         i_array_rdata,
    output logic                      o_busy
);
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
`ifdef WRITE_VERIFY_EN
        , ST_VERIFY
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef WRITE_VERIFY_EN
    logic              error_q, error_d;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef WRITE_VERIFY_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef WRITE_VERIFY_EN
            error_q <= error_d;
`endif
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifdef WRITE_VERIFY_EN
        error_d    = error_q;
`endif
        o_valid    = 1'b0;
        o_array_we = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req_valid) begin
                    write_d = bus.i_req_write;
                    addr_d  = bus.i_req_address;
                    wdata_d = bus.i_req_wdata;
                    cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                o_valid = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACCESS: begin
                o_valid    = 1'b1;
                o_array_we = write_q;
                if (!write_q) begin
                    rdata_d = i_array_rdata;
                end
                state_d = ST_DONE;
`ifdef WRITE_VERIFY_EN
                if (write_q) begin
                    state_d = ST_VERIFY;
                end
`endif
            end
`ifdef WRITE_VERIFY_EN
            ST_VERIFY: begin
                o_valid = 1'b1;
                error_d = (i_array_rdata != wdata_q);
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (bus.i_resp_ready) begin
                    rdata_d = '0;
`ifdef WRITE_VERIFY_EN
                    error_d = 1'b0;
`endif
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address and data reach the decoder/array only while the word is selected.
    assign o_k_address      = o_valid ? addr_q  : '0;
    assign o_array_wdata    = o_valid ? wdata_q : '0;

    assign bus.o_req_ready  = (state_q == ST_IDLE);
    assign bus.o_resp_valid = (state_q == ST_DONE);
    assign bus.o_resp_rdata = rdata_q;
`ifdef WRITE_VERIFY_EN
    assign bus.o_resp_error = error_q;
`else
    assign bus.o_resp_error = 1'b0;
`endif
    assign o_busy           = (state_q != ST_IDLE);
endmodule

// File: doc/memory_access_controller.md
Name: memory_access_controller

Overview:
- Sequences single-word read and write accesses to the 8x8 memory array.
- Accepts one request at a time over a valid/ready handshake.
- Drives the 3-bit word address and the valid enable of the address decoder, plus the array write enable and write data.
- Returns read data or write completion over a valid/ready response channel.

Parameters:
DATA_W, 8, word width of the array and of the request/response data
ADDR_W, 3, word address width; must be 3 to match the decoder (8 words)
SETUP_CYCLES, 1, cycles the address and decoder valid are held before the access cycle; legal range 1..15

Ports:
i_clk  input  1  clock; all state changes on the rising edge
i_rst  input  1  synchronous, active-high reset
i_req_valid  input  1  request present
o_req_ready  output  1  controller can accept a request (IDLE only)
i_req_write  input  1  1 = write, 0 = read
i_req_address  input  ADDR_W  target word
i_req_wdata  input  DATA_W  write data
o_resp_valid  output  1  response present
i_resp_ready  input  1  consumer accepts the response
o_resp_rdata  output  DATA_W  read data; 0 for writes
o_resp_error  output  1  write-verify mismatch; constant 0 without the feature
o_k_address  output  ADDR_W  to decoder i_k_address
o_valid  output  1  to decoder valid (word select enable)
o_array_we  output  1  array write strobe; the array writes on the rising edge while o_array_we=1
o_array_wdata  output  DATA_W  data to array
i_array_rdata  input  DATA_W  combinational read data of the selected word
o_busy  output  1  high in every state except IDLE

Behaviour:
- Interface: single clock i_clk; reset i_rst is synchronous and active-high.
- Reset values (the edge at which i_rst=1 is sampled):
  - State goes to IDLE and all registers clear.
  - o_req_ready=1; all other outputs 0.
- States:
  - IDLE, SETUP, ACCESS, DONE.
  - VERIFY exists only with the optional feature.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid=1, capture the request fields (write flag, address, wdata), load the setup counter with SETUP_CYCLES-1, and go to SETUP.
- SETUP:
  - o_k_address = captured address; o_valid=1; o_array_we=0; o_array_wdata = captured wdata.
  - The counter decrements each cycle; go to ACCESS when it is 0.
- ACCESS:
  - o_valid=1 with the same address.
  - Write: o_array_we=1 for exactly this one cycle.
  - Read: register i_array_rdata into o_resp_rdata at the end of the cycle.
  - Next state is DONE, or VERIFY for a write when the feature is compiled in.
- DONE:
  - o_resp_valid=1; o_valid=0; o_array_we=0.
  - o_resp_rdata and o_resp_error hold stable until i_resp_ready=1, then go to IDLE.
  - o_resp_rdata and o_resp_error clear on the move to IDLE.
- Latency: request accepted at edge N → o_resp_valid high in cycle N+SETUP_CYCLES+2 (default 3) without verify.
- Back-to-back: the next request is accepted no earlier than the cycle after the response handshake (no overlap).
- Requests while busy: i_req_valid is ignored while o_req_ready=0; request inputs are not sampled outside IDLE.
- Decoder/array outputs:
  - o_valid and o_array_we are never 1 in IDLE or DONE.
  - o_array_we=1 only in ACCESS, and only for writes.
  - o_k_address is stable for the whole SETUP..ACCESS (..VERIFY) span.
- Reset mid-operation:
  - The sampled reset edge forces IDLE.
  - A write strobe present on that edge may complete; no strobe occurs afterwards.
  - A pending response is dropped.
- Simultaneous i_rst with i_req_valid: reset wins; the request is not captured.

Optional Feature:
Macro WRITE_VERIFY_EN.
- Defined:
  - A write goes ACCESS → VERIFY.
  - VERIFY: o_valid=1, o_array_we=0, same address; compare i_array_rdata with the captured wdata, register o_resp_error=1 on mismatch, then go to DONE.
  - Write latency becomes SETUP_CYCLES+3.
  - Reads are unaffected.
- Not defined:
  - No VERIFY state; o_resp_error tied to 0.

Test Plan:
- Reset then idle: assert i_rst 2 cycles → o_req_ready=1, o_valid=0, o_array_we=0, o_resp_valid=0, o_busy=0.
- Write then read, default SETUP_CYCLES=1:
  - Write addr 3, data 0xA5 → o_k_address=3 and o_valid=1 for 2 cycles, o_array_we=1 exactly 1 cycle, o_resp_valid at cycle +3.
  - Read addr 3 → o_resp_rdata=0xA5.
- Response backpressure: read addr 7 (data 0x3C) with i_resp_ready=0 for 5 cycles → o_resp_valid and o_resp_rdata=0x3C held; a new request during that time is not accepted (o_req_ready=0).
- SETUP_CYCLES=4: read addr 0 → o_valid high 5 cycles before the response; o_resp_valid at cycle +6.
- Reset mid-operation: i_rst in SETUP of a write to addr 5 with 0xFF → o_array_we never asserts; word 5 unchanged; controller in IDLE next cycle.
- WRITE_VERIFY_EN defined:
  - Write 0x5A with the array model forcing bit 0 stuck at 1 → o_resp_error=1, response at cycle +4.
  - Fault-free array → o_resp_error=0.
